// File: rtl/ram_ctrl_pkg.sv
// Shared encodings and defaults for the block-RAM port sequencer and its arbiter.
package ram_ctrl_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WRITE     = 3'd1,
      ST_READ      = 3'd2,
      ST_READ_WAIT = 3'd3,
      ST_FILL      = 3'd4
   } state_t;

   typedef enum logic {
      GNT_WRITE = 1'b0,
      GNT_READ  = 1'b1
   } grant_t;

   // Bit positions inside the one-hot grant vector.
   localparam int GNT_BIT_WR = 0;
   localparam int GNT_BIT_RD = 1;

   // Round-robin choice: on conflict the side that did not win last time goes next.
   function automatic grant_t rr_pick(input logic wr, input logic rd, input grant_t last);
      if (wr && rd) begin
         return (last == GNT_WRITE) ? GNT_READ : GNT_WRITE;
      end
      if (rd) begin
         return GNT_READ;
      end
      return GNT_WRITE;
   endfunction

endpackage

// File: rtl/ram_rr_arb2.sv
// Two-way round-robin arbiter between the pending manual write and read requests.
module ram_rr_arb2
   import ram_ctrl_pkg::*;
(
   input  logic       clk_95HZ,
   input  logic       clr,
   input  logic       wr_pend_i,
   input  logic       rd_pend_i,
   input  logic       accept_i,
   output logic [1:0] gnt_o
);

   grant_t last_grant_q;
   grant_t last_grant_d;
   grant_t pick;
   logic   any_pend;

   assign any_pend = wr_pend_i || rd_pend_i;

   // NOTE: every signal written here gets a default first, so no path can leave it
   // unassigned and infer a latch.
   always_comb begin
      pick         = rr_pick(wr_pend_i, rd_pend_i, last_grant_q);
      gnt_o        = '0;
      last_grant_d = last_grant_q;
      if (any_pend) begin
         if (pick == GNT_READ) begin
            gnt_o[GNT_BIT_RD] = 1'b1;
         end else begin
            gnt_o[GNT_BIT_WR] = 1'b1;
         end
      end
      if (accept_i && any_pend) begin
         last_grant_d = pick;
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk_95HZ or posedge clr) begin
      if (clr) begin
         last_grant_q <= GNT_WRITE;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/ram_port_ctrl.sv
// Sequencer for the single-port 16x8 block RAM: manual write/read with round-robin
// sharing plus an auto-fill burst. The RAM array itself is external and is not cleared by clr.
module ram_port_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk_95HZ,
   input  logic              clr,
   input  logic              wr_req,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_req,
   input  logic              fill_start,
   input  logic [DATA_W-1:0] fill_seed,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              wr_ack,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic [ADDR_W-1:0] rd_ptr,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] IDX_LAST = '1;

   state_t            state_q,     state_d;
   logic              wr_pend_q,   wr_pend_d;
   logic              rd_pend_q,   rd_pend_d;
   logic              fill_pend_q, fill_pend_d;
   logic [DATA_W-1:0] wr_data_q,   wr_data_d;
   logic [DATA_W-1:0] seed_q,      seed_d;
   logic [DATA_W-1:0] rd_data_q,   rd_data_d;
   logic              rd_valid_q,  rd_valid_d;
   logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q,    rd_ptr_d;
   logic [ADDR_W-1:0] idx_q,       idx_d;

   logic [1:0] gnt;
   logic       accept;
   logic       wr_done;
   logic       rd_done;
   logic       fill_done;

   // Fill outranks manual traffic, so the arbiter only commits when no fill waits.
   assign accept = (state_q == ST_IDLE) && !fill_pend_q;

   ram_rr_arb2 u_arb (
      .clk_95HZ  (clk_95HZ),
      .clr       (clr),
      .wr_pend_i (wr_pend_q),
      .rd_pend_i (rd_pend_q),
      .accept_i  (accept),
      .gnt_o     (gnt)
   );

   assign wr_done   = (state_q == ST_WRITE);
   assign rd_done   = (state_q == ST_READ_WAIT);
   assign fill_done = (state_q == ST_FILL) && (idx_q == IDX_LAST);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         ST_IDLE: begin
            if (fill_pend_q) begin
               state_d = ST_FILL;
               idx_d   = '0;
            end else if (gnt[GNT_BIT_WR]) begin
               state_d = ST_WRITE;
            end else if (gnt[GNT_BIT_RD]) begin
               state_d = ST_READ;
            end
         end
         ST_WRITE:     state_d = ST_IDLE;
         ST_READ:      state_d = ST_READ_WAIT;
         ST_READ_WAIT: state_d = ST_IDLE;
         ST_FILL: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
               state_d = ST_IDLE;
            end
         end
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_pend_d   = wr_pend_q;
      rd_pend_d   = rd_pend_q;
      fill_pend_d = fill_pend_q;
      wr_data_d   = wr_data_q;
      seed_d      = seed_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;

      if (wr_done) begin
         wr_pend_d = 1'b0;
         wr_ptr_d  = wr_ptr_q + 1'b1;
      end
      if (rd_done) begin
         rd_pend_d  = 1'b0;
         rd_ptr_d   = rd_ptr_q + 1'b1;
         rd_data_d  = ram_dout;
         rd_valid_d = 1'b1;
      end
      if (fill_done) begin
         fill_pend_d = 1'b0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
      end

      // A pulse seen while its flag is still set is dropped and its data ignored.
      if (wr_req && !wr_pend_q) begin
         wr_pend_d = 1'b1;
         wr_data_d = wr_data;
      end
      if (rd_req && !rd_pend_q) begin
         rd_pend_d = 1'b1;
      end
      if (fill_start && !fill_pend_q) begin
         fill_pend_d = 1'b1;
         seed_d      = fill_seed;
      end
   end

   always_comb begin
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
      wr_ack   = 1'b0;
      unique case (state_q)
         ST_WRITE: begin
            ram_we   = 1'b1;
            ram_addr = wr_ptr_q;
            ram_din  = wr_data_q;
            wr_ack   = 1'b1;
         end
         ST_READ, ST_READ_WAIT: begin
            ram_addr = rd_ptr_q;
         end
         ST_FILL: begin
            ram_we   = 1'b1;
            ram_addr = idx_q;
            ram_din  = seed_q + DATA_W'(idx_q);
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk_95HZ or posedge clr) begin
      if (clr) begin
         state_q     <= ST_IDLE;
         wr_pend_q   <= 1'b0;
         rd_pend_q   <= 1'b0;
         fill_pend_q <= 1'b0;
         wr_data_q   <= '0;
         seed_q      <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         idx_q       <= '0;
      end else begin
         state_q     <= state_d;
         wr_pend_q   <= wr_pend_d;
         rd_pend_q   <= rd_pend_d;
         fill_pend_q <= fill_pend_d;
         wr_data_q   <= wr_data_d;
         seed_q      <= seed_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         idx_q       <= idx_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign wr_ptr   = wr_ptr_q;
   assign rd_ptr   = rd_ptr_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Bench for ram_port_ctrl: a behavioural 16x8 RAM, a vector table, directed corner
// sequences and a random run compared cycle by cycle against a job-level model.
module tb_ram_port_ctrl;

   localparam int DEPTH  = 16;
   localparam int J_NONE = 0;
   localparam int J_WR   = 1;
   localparam int J_RD   = 2;
   localparam int J_FILL = 3;

   logic       clk_95HZ = 1'b0;
   logic       clr;
   logic       wr_req, rd_req, fill_start;
   logic [7:0] wr_data, fill_seed, ram_dout;
   logic       ram_we;
   logic [3:0] ram_addr;
   logic [7:0] ram_din, rd_data;
   logic       rd_valid, wr_ack, busy;
   logic [3:0] wr_ptr, rd_ptr;

   ram_port_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk_95HZ   (clk_95HZ),
      .clr        (clr),
      .wr_req     (wr_req),
      .wr_data    (wr_data),
      .rd_req     (rd_req),
      .fill_start (fill_start),
      .fill_seed  (fill_seed),
      .ram_dout   (ram_dout),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .wr_ack     (wr_ack),
      .wr_ptr     (wr_ptr),
      .rd_ptr     (rd_ptr),
      .busy       (busy)
   );

   initial forever #5 clk_95HZ = ~clk_95HZ;

   typedef struct packed {
      logic       we;
      logic [3:0] addr;
      logic [7:0] din;
      logic       ack;
      logic       rv;
      logic [7:0] rdat;
      logic       busy;
      logic [3:0] wp;
      logic [3:0] rp;
   } obs_t;

   typedef struct {
      logic       w;
      logic [7:0] wd;
      logic       r;
      logic       f;
      logic [7:0] fs;
      obs_t       exp;
   } vec_t;

   // Behavioural RAM: one-cycle read latency, contents survive clr.
   logic [7:0] mem [DEPTH];
   logic       ram_load;

   function automatic logic [7:0] init_word(input int i);
      return 8'(8'h30 + 3 * i);
   endfunction

   always @(posedge clk_95HZ) begin
      if (ram_load) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
      end else if (ram_we) begin
         mem[ram_addr] <= ram_din;
      end
      ram_dout <= mem[ram_addr];
   end

   int    n_tests = 0;
   int    n_fail  = 0;
   bit    chk_en;
   string phase;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Job-level reference: one job at a time, pending requests as booleans, a shadow memory.
   int         m_job, m_step, m_wp, m_rp;
   bit         m_pw, m_pr, m_pf, m_last_rd, m_rv;
   logic [7:0] m_wd, m_seed, m_rd;
   logic [7:0] shadow [DEPTH];

   task automatic mdl_reset();
      m_job = J_NONE; m_step = 0; m_wp = 0; m_rp = 0;
      m_pw = 0; m_pr = 0; m_pf = 0; m_last_rd = 0; m_rv = 0;
      m_wd = 0; m_seed = 0; m_rd = 0;
   endtask

   task automatic mdl_step(input logic w, input logic [7:0] wd, input logic r,
                           input logic f, input logic [7:0] fs);
      bit opw = m_pw;
      bit opr = m_pr;
      bit opf = m_pf;
      m_rv = 0;
      case (m_job)
         J_NONE: begin
            if (opf) begin
               m_job = J_FILL; m_step = 0;
            end else if (opw && (!opr || m_last_rd)) begin
               m_job = J_WR; m_last_rd = 0;
            end else if (opr) begin
               m_job = J_RD; m_step = 0; m_last_rd = 1;
            end
         end
         J_WR: begin
            shadow[m_wp] = m_wd;
            m_wp = (m_wp + 1) % DEPTH;
            m_pw = 0;
            m_job = J_NONE;
         end
         J_RD: begin
            if (m_step == 0) begin
               m_step = 1;
            end else begin
               m_rd = shadow[m_rp];
               m_rv = 1;
               m_rp = (m_rp + 1) % DEPTH;
               m_pr = 0;
               m_job = J_NONE;
            end
         end
         default: begin
            shadow[m_step] = 8'(m_seed + m_step);
            if (m_step == DEPTH - 1) begin
               m_pf = 0; m_wp = 0; m_rp = 0; m_job = J_NONE;
            end else begin
               m_step++;
            end
         end
      endcase
      if (w && !opw) begin m_pw = 1; m_wd = wd; end
      if (r && !opr) m_pr = 1;
      if (f && !opf) begin m_pf = 1; m_seed = fs; end
   endtask

   function automatic obs_t mdl_obs();
      obs_t o = '0;
      o.rv   = m_rv;
      o.rdat = m_rd;
      o.wp   = 4'(m_wp);
      o.rp   = 4'(m_rp);
      case (m_job)
         J_WR:   begin o.we = 1; o.addr = 4'(m_wp); o.din = m_wd; o.ack = 1; o.busy = 1; end
         J_RD:   begin o.addr = 4'(m_rp); o.busy = 1; end
         J_FILL: begin o.we = 1; o.addr = 4'(m_step); o.din = 8'(m_seed + m_step); o.busy = 1; end
         default: begin end
      endcase
      return o;
   endfunction

   function automatic obs_t dut_obs();
      obs_t o;
      o.we = ram_we; o.addr = ram_addr; o.din = ram_din; o.ack = wr_ack;
      o.rv = rd_valid; o.rdat = rd_data; o.busy = busy; o.wp = wr_ptr; o.rp = rd_ptr;
      return o;
   endfunction

   function automatic obs_t mk(input logic we, input logic [3:0] addr, input logic [7:0] din,
                               input logic ack, input logic rv, input logic [7:0] rdat,
                               input logic bsy, input logic [3:0] wp, input logic [3:0] rp);
      obs_t o;
      o.we = we; o.addr = addr; o.din = din; o.ack = ack; o.rv = rv;
      o.rdat = rdat; o.busy = bsy; o.wp = wp; o.rp = rp;
      return o;
   endfunction

   // One clock: drive at the falling edge, step the model at the rising edge, sample at the next falling edge.
   task automatic cycle(input logic w, input logic [7:0] wd, input logic r,
                        input logic f, input logic [7:0] fs);
      wr_req = w; wr_data = wd; rd_req = r; fill_start = f; fill_seed = fs;
      @(posedge clk_95HZ);
      mdl_step(w, wd, r, f, fs);
      @(negedge clk_95HZ);
      wr_req = 0; rd_req = 0; fill_start = 0;
      if (chk_en) check(phase, dut_obs(), mdl_obs());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic do_reset(input string tag);
      clr = 1'b1;
      #1;
      check({tag, "/reset_zero"}, dut_obs(), '0);
      @(posedge clk_95HZ);
      @(negedge clk_95HZ);
      clr = 1'b0;
      mdl_reset();
   endtask

   vec_t tbl [$];

   task automatic add(input logic w, input logic [7:0] wd, input logic r,
                      input logic f, input logic [7:0] fs, input obs_t e);
      tbl.push_back('{w: w, wd: wd, r: r, f: f, fs: fs, exp: e});
   endtask

   logic [7:0] pre7, pre8, e_din;

   initial begin
      clr = 1'b1; ram_load = 1'b1; chk_en = 0; phase = "init";
      wr_req = 0; rd_req = 0; fill_start = 0; wr_data = 0; fill_seed = 0;
      for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
      mdl_reset();
      repeat (2) @(posedge clk_95HZ);
      @(negedge clk_95HZ);
      ram_load = 1'b0;
      check("init/reset_zero", dut_obs(), '0);
      clr = 1'b0;

      // write A5, read it back, dropped pulses, then a conflict after a lone write
      add(1, 8'hA5, 0, 0, 0, mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0));
      add(0, 8'h00, 0, 0, 0, mk(1, 0, 8'hA5, 1, 0, 8'h00, 1, 0, 0));
      add(0, 8'h00, 0, 0, 0, mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0));
      add(0, 8'h00, 1, 0, 0, mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0));
      add(0, 8'h00, 0, 0, 0, mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0));
      add(0, 8'h00, 0, 0, 0, mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0));
      add(0, 8'h00, 0, 0, 0, mk(0, 0, 8'h00, 0, 1, 8'hA5, 0, 1, 1));
      add(0, 8'h00, 0, 0, 0, mk(0, 0, 8'h00, 0, 0, 8'hA5, 0, 1, 1));
      add(1, 8'h5A, 0, 0, 0, mk(0, 0, 8'h00, 0, 0, 8'hA5, 0, 1, 1));
      add(1, 8'h77, 0, 0, 0, mk(1, 1, 8'h5A, 1, 0, 8'hA5, 1, 1, 1));
      add(1, 8'h99, 0, 0, 0, mk(0, 0, 8'h00, 0, 0, 8'hA5, 0, 2, 1));
      add(0, 8'h00, 0, 0, 0, mk(0, 0, 8'h00, 0, 0, 8'hA5, 0, 2, 1));
      add(1, 8'hC3, 1, 0, 0, mk(0, 0, 8'h00, 0, 0, 8'hA5, 0, 2, 1));
      add(0, 8'h00, 0, 0, 0, mk(0, 1, 8'h00, 0, 0, 8'hA5, 1, 2, 1));
      add(0, 8'h00, 0, 0, 0, mk(0, 1, 8'h00, 0, 0, 8'hA5, 1, 2, 1));
      add(0, 8'h00, 0, 0, 0, mk(0, 0, 8'h00, 0, 1, 8'h5A, 0, 2, 2));
      add(0, 8'h00, 0, 0, 0, mk(1, 2, 8'hC3, 1, 0, 8'h5A, 1, 2, 2));
      add(0, 8'h00, 0, 0, 0, mk(0, 0, 8'h00, 0, 0, 8'h5A, 0, 3, 2));
      foreach (tbl[i]) begin
         cycle(tbl[i].w, tbl[i].wd, tbl[i].r, tbl[i].f, tbl[i].fs);
         check($sformatf("table[%0d]", i), dut_obs(), tbl[i].exp);
      end

      // Conflict straight after reset: read wins, then write; alternation afterwards.
      chk_en = 1; phase = "conflict";
      do_reset("conflict");
      cycle(1, 8'h11, 1, 0, 8'h00);
      cycle(0, 8'h00, 0, 0, 8'h00);
      check("conflict_rd_first", {26'd0, ram_we, ram_addr, busy}, {26'd0, 1'b0, 4'd0, 1'b1});
      idle(3);
      check("conflict_wr_second", {18'd0, ram_we, ram_addr, ram_din, wr_ack},
            {18'd0, 1'b1, 4'd0, 8'h11, 1'b1});
      idle(1);
      cycle(0, 8'h00, 1, 0, 8'h00);
      idle(3);
      cycle(1, 8'h22, 1, 0, 8'h00);
      cycle(0, 8'h00, 0, 0, 8'h00);
      check("conflict_wr_first", {18'd0, ram_we, ram_addr, ram_din, busy},
            {18'd0, 1'b1, 4'd1, 8'h22, 1'b1});
      idle(5);

      // Fill from F8 with a write request arriving mid-burst.
      phase = "fill";
      cycle(0, 8'h00, 0, 1, 8'hF8);
      for (int i = 0; i < DEPTH; i++) begin
         cycle(i == 3, 8'h3C, 1'b0, 1'b0, 8'h00);
         e_din = 8'hF8 + 8'(i);
         check($sformatf("fill_cycle[%0d]", i), {17'd0, ram_we, ram_addr, ram_din, wr_ack, busy},
               {17'd0, 1'b1, 4'(i), e_din, 1'b0, 1'b1});
      end
      cycle(0, 8'h00, 0, 0, 8'h00);
      check("fill_ptrs", {23'd0, wr_ptr, rd_ptr, busy}, 32'd0);
      cycle(0, 8'h00, 0, 0, 8'h00);
      check("fill_queued_wr", {18'd0, ram_we, ram_addr, ram_din, wr_ack},
            {18'd0, 1'b1, 4'd0, 8'h3C, 1'b1});
      idle(2);

      // Seventeen manual writes: the last one wraps to address 0.
      phase = "wrap";
      do_reset("wrap");
      for (int n = 0; n < 17; n++) begin
         cycle(1, 8'(8'h80 + n), 0, 0, 8'h00);
         cycle(0, 8'h00, 0, 0, 8'h00);
         if (n == 16) check("wrap_addr", {19'd0, ram_we, ram_addr, ram_din},
                            {19'd0, 1'b1, 4'd0, 8'h90});
         cycle(0, 8'h00, 0, 0, 8'h00);
      end
      check("wrap_ptr", {28'd0, wr_ptr}, 32'd1);

      // Abort a fill at index 7 with clr.
      phase = "abort";
      pre7 = mem[7];
      pre8 = mem[8];
      cycle(0, 8'h00, 0, 1, 8'h50);
      idle(8);
      check("abort_at7", {27'd0, ram_we, ram_addr}, {27'd0, 1'b1, 4'd7});
      clr = 1'b1;
      #1;
      check("abort_zero", dut_obs(), '0);
      @(posedge clk_95HZ);
      mdl_reset();
      @(negedge clk_95HZ);
      clr = 1'b0;
      check("abort_wr6", {24'd0, mem[6]}, {24'd0, 8'h56});
      check("abort_no_wr7", {24'd0, mem[7]}, {24'd0, pre7});
      check("abort_no_wr8", {24'd0, mem[8]}, {24'd0, pre8});
      idle(3);
      check("abort_idle", {31'd0, busy}, 32'd0);

      // Random traffic against the model.
      phase = "random";
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 1499) == 0) do_reset("random");
         cycle($urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 5) == 0,
               $urandom_range(0, 79) == 0, 8'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_port_ctrl.md
Name: ram_port_ctrl

Overview:
- Sequencer and arbiter for the single-port 16x8 block RAM.
- Shares the one RAM port between a button-driven writer and a button-driven reader, with round-robin arbitration on conflict.
- Adds an auto-fill sequence that writes all 16 locations back-to-back.
- Sits between the debounced clock_pulse outputs and the RAM. It replaces the ad-hoc read/write counters and the wea-based address mux.

Parameters:
- DATA_W, 8, RAM word width.
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W; fill length = depth.

Ports:
- clk_95HZ  in  1  system clock for this block (debounced-button domain).
- clr  in  1  reset, asynchronous, active-high.
- wr_req  in  1  single-cycle write request pulse.
- wr_data  in  DATA_W  write data, sampled on the cycle wr_req is high.
- rd_req  in  1  single-cycle read request pulse.
- fill_start  in  1  single-cycle auto-fill request pulse.
- fill_seed  in  DATA_W  fill base value, sampled with fill_start.
- ram_dout  in  DATA_W  RAM read data; valid one clk_95HZ cycle after address is presented.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- rd_data  out  DATA_W  last read word (held until the next read).
- rd_valid  out  1  one-cycle pulse when rd_data updates.
- wr_ack  out  1  one-cycle pulse, coincident with the RAM write cycle.
- wr_ptr  out  ADDR_W  next manual write address.
- rd_ptr  out  ADDR_W  next manual read address.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (clr=1, asynchronous):
  - Outputs: all 0.
  - State: IDLE.
  - Registers: pending flags cleared, last_grant=WRITE, fill index 0.
  - Effect: takes hold immediately, including mid-FILL or mid-READ. ram_we drops with no further writes.
- Request latching:
  - wr_req, rd_req and fill_start each set a pending flag (wr_pend, rd_pend, fill_pend) at the edge they are sampled.
  - wr_data and fill_seed are latched at the same edge.
  - A pulse arriving while its flag is already set is dropped; the latched data is not overwritten.
  - Requests arriving in any state, including FILL, are latched.
- States: IDLE, WRITE, READ, READ_WAIT, FILL.
- IDLE: decides from pending flags only (one-cycle minimum latency). Priority order:
  - fill_pend: go to FILL, fill index=0.
  - wr_pend and rd_pend both set: grant the requester opposite last_grant, update last_grant.
  - Only one pending: grant it, update last_grant.
- WRITE (1 cycle):
  - ram_we=1, ram_addr=wr_ptr, ram_din=latched data, wr_ack=1.
  - On exit: clear wr_pend, wr_ptr+1 (15 wraps to 0), go to IDLE.
- READ (1 cycle): ram_we=0, ram_addr=rd_ptr; go to READ_WAIT.
- READ_WAIT (1 cycle):
  - ram_addr held at rd_ptr.
  - At exit edge: rd_data<=ram_dout, rd_valid=1 for the following cycle, rd_ptr+1 (wrap), clear rd_pend, go to IDLE.
- FILL (2**ADDR_W cycles):
  - Each cycle: ram_we=1, ram_addr=idx, ram_din=seed+idx (mod 2**DATA_W), idx+1.
  - After idx=15: clear fill_pend, wr_ptr=0, rd_ptr=0, go to IDLE.
  - last_grant is unchanged by FILL.
  - wr_ack is not asserted during FILL.
- ram_we is 0 in every state other than WRITE and FILL.
- ram_addr/ram_din are 0 in IDLE.
- Request-to-access latency:
  - Write: pulse sampled at edge E0; RAM write occurs in the cycle after E1.
  - Read: rd_valid is high in the cycle after E3.
- Back-to-back service: after WRITE or READ_WAIT the FSM always passes through one IDLE cycle.
- Pointers are free-running modulo depth. There is no full/empty tracking: reads of unwritten locations return RAM contents.

Decomposition:
- Shared package ram_ctrl_pkg:
  - state encoding constants ST_IDLE, ST_WRITE, ST_READ, ST_READ_WAIT, ST_FILL (3-bit).
  - grant encoding GNT_WRITE=0, GNT_READ=1.
  - DATA_W/ADDR_W defaults.
- Sub-module ram_rr_arb2: 2-way round-robin arbiter.
  - Inputs: wr_pend, rd_pend.
  - Register: last_grant, updated on an accept strobe.
  - Output: one-hot grant.
- FSM, pointers and datapath stay in ram_port_ctrl.

Test Plan:
- Reset: assert clr mid-run -> all outputs 0 immediately, busy=0, wr_ptr=rd_ptr=0.
- Manual write: wr_data=8'hA5 with wr_req pulse -> exactly one cycle ram_we=1, ram_addr=0, ram_din=8'hA5, wr_ack=1; afterwards wr_ptr=1.
- Read-back: rd_req after the above -> ram_addr=0 for 2 cycles with ram_we=0; then rd_data=8'hA5, rd_valid one cycle, rd_ptr=1.
- Conflict after reset: wr_req and rd_req on the same cycle -> READ serviced first, then WRITE. Repeat the same stimulus -> WRITE first.
- Fill: fill_seed=8'hF8 with fill_start -> 16 consecutive write cycles, addr 0..15, data F8..FF then 00..07, busy=1 throughout, no wr_ack.
  - wr_req=8'h3C issued during fill -> serviced after fill at addr 0, ptrs reset to 0 first.
- Wrap and abort:
  - 17 manual writes -> 17th write lands at addr 0.
  - clr pulse at fill idx=7 -> ram_we drops at once, state IDLE, fill_pend cleared, no write to addr 8.
